fft_bfly_engine: RTL and testbench
==================================

// Module: fft_bfly_engine
// PURPOSE
//  In-place radix-2 DIT FFT compute engine; consumer side of the twiddle interface (stage -> Wn bus).
//  Loads one frame of FFT_LEN complex samples (bit-reversed order) and iterates stages 0..STG_NUM-1.
//  Each stage: drives stage_o to fft_gen_wn, registers returned Wn bus, runs FFT_LEN/2 butterflies, writes back.
//  Sits between the bit-reverse input buffer and the output/unload logic of the FFT datapath.
// PARAMETERS
//  FFT_LEN  `FFT_LEN (8)  points per frame; power of 2
//  STG_NUM  log2(FFT_LEN) (3)  number of butterfly stages
//  STG_WID  `STG_WID (2)  width of stage_o
//  DAT_WID  16  signed two's-complement width of each re/im sample
//  WN_WID   `WN_WID (10)  signed twiddle width
//  WN_FRAC  8  twiddle fraction bits (256 = +1.0)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  synchronous, active-high reset
//  start_i      in   1                  load frame and begin; honoured only in IDLE
//  dat_re_i     in   FFT_LEN*DAT_WID    input real parts, sample n at [n*DAT_WID +: DAT_WID], bit-reversed order
//  dat_im_i     in   FFT_LEN*DAT_WID    input imaginary parts, same packing
//  stage_o      out  STG_WID            stage index to twiddle generator
//  fft_wn_re_i  in   FFT_LEN/2*WN_WID   twiddle real, butterfly k at [k*WN_WID +: WN_WID]
//  fft_wn_im_i  in   FFT_LEN/2*WN_WID   twiddle imaginary, same packing
//  busy_o       out  1                  high from cycle after accepted start until done_o
//  done_o       out  1                  one-cycle pulse; result valid
//  dat_re_o     out  FFT_LEN*DAT_WID    result real, natural order; held until next accepted start
//  dat_im_o     out  FFT_LEN*DAT_WID    result imaginary, same packing
// BEHAVIOUR
//  Reset: state=IDLE; stage_o=0, busy_o=0, done_o=0, dat_re_o/dat_im_o=0, work regs=0. Applies mid-frame: aborts, no done_o.
//  FSM: IDLE -(start_i)-> FETCH -> MUL -> ADD -> (stage<STG_NUM-1 ? FETCH with stage+1 : DONE) -> IDLE.
//  IDLE: start_i=1 captures dat_*_i into work regs, stage counter=0. start_i in any other state ignored.
//  FETCH: stage_o = stage counter (stable FETCH..ADD); Wn bus treated as combinational, registered at end of FETCH.
//  MUL: per butterfly k: g=k>>s, j=k&(2^s-1), top=g*2^(s+1)+j, bot=top+2^s.
//   P = Wk*X[bot], complex; each real product rounded: (p + 2^(WN_FRAC-1)) >>> WN_FRAC, kept at DAT_WID+1 bits.
//  ADD: X'[top]=(X[top]+P)>>>1, X'[bot]=(X[top]-P)>>>1, sums at DAT_WID+2 bits, arithmetic shift, truncate to DAT_WID.
//   Scaling 1/2 per stage -> output = DFT/FFT_LEN; no overflow for in-range inputs, no saturation logic.
//  DONE: work regs copied to dat_*_o, done_o=1 for exactly this cycle, busy_o=0 from next cycle.
//  Latency: start_i sampled at cycle T -> done_o at T+1+3*STG_NUM (T+10 for FFT_LEN=8).
//  start_i high in the DONE cycle ignored; accepted on first IDLE cycle. Back-to-back frames: one IDLE cycle gap.
//  stage_o returns to 0 in IDLE/DONE. Wn values for stage indices >=STG_NUM never used.
// STRUCTURE
//  Shared header fft_defines.vh: `FFT_LEN, `STG_WID, `WN_WID, `DAT_WID, `WN_FRAC, FSM state encodings.
//  Sub-module fft_bfly: one complex butterfly, MUL and ADD register stages, instantiated FFT_LEN/2 times via generate.
//  Top holds FSM, stage counter, work regs, top/bot index muxing per stage.
//  Same-cycle (FETCH) connection to fft_gen_wn; integration test pairs the two modules.
// TESTING
//  Impulse: re[0]=100, rest 0 -> all dat_re_o=12, dat_im_o=0; done_o at T+10, single-cycle pulse.
//  DC: all re=64 -> dat_re_o[0]=64, others 0, all im 0.
//  Tone: x[n]=cos(2*pi*n/8)*128 loaded bit-reversed -> bins 1 and 7 re=64 (+-1 rounding), others |.|<=1.
//  stage_o trace: 0 for FETCH/MUL/ADD cycles 1-3, 1 for 4-6, 2 for 7-9, 0 otherwise; busy_o high cycles 1-9.
//  start_i pulsed while busy and in DONE -> ignored, result unchanged; re-asserted in IDLE -> new frame accepted.
//  rst asserted at cycle 5 of a frame -> next cycle all outputs 0, IDLE, no done_o; fresh start runs normally.
//  Negative full-scale inputs (-32768 all re) -> dat_re_o[0]=-32768, others 0; no wrap.

Source files
------------

// File: rtl/fft_bfly_engine_pkg.sv
// Shared sizing, FSM encoding and butterfly index helpers for the in-place radix-2 DIT engine.
package fft_bfly_engine_pkg;

    localparam int FFT_LEN  = 8;
    localparam int STG_NUM  = $clog2(FFT_LEN);
    localparam int STG_WID  = 2;
    localparam int DAT_WID  = 16;
    localparam int WN_WID   = 10;
    localparam int WN_FRAC  = 8;
    localparam int BFLY_NUM = FFT_LEN / 2;
    localparam int IDX_WID  = $clog2(FFT_LEN);
    localparam int BIDX_WID = $clog2(BFLY_NUM);
    localparam int MUL_WID  = DAT_WID + WN_WID;
    localparam int PRD_WID  = DAT_WID + 1;
    localparam int SUM_WID  = DAT_WID + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MUL   = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Butterfly k at stage s: group k>>s spans 2^(s+1) samples, offset k&(2^s-1) inside it.
    function automatic logic [IDX_WID-1:0] top_idx(input logic [IDX_WID-1:0] k,
                                                   input logic [STG_WID-1:0] s);
        logic [IDX_WID-1:0] lo_mask;
        lo_mask = (IDX_WID'(1) << s) - IDX_WID'(1);
        return ((k & ~lo_mask) << 1) | (k & lo_mask);
    endfunction

    // Inverse mapping: which butterfly owns sample n at stage s.
    function automatic logic [BIDX_WID-1:0] owner_idx(input logic [IDX_WID-1:0] n,
                                                      input logic [STG_WID-1:0] s);
        logic [IDX_WID-1:0] lo_mask;
        lo_mask = (IDX_WID'(1) << s) - IDX_WID'(1);
        return BIDX_WID'(((n >> 1) & ~lo_mask) | (n & lo_mask));
    endfunction

endpackage

// File: rtl/fft_bfly_engine_bfly.sv
// One complex butterfly: registered twiddle product (MUL), combinational scaled sum/difference (ADD).
module fft_bfly_engine_bfly
    import fft_bfly_engine_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mul_en,
    input  logic signed [WN_WID-1:0]  wn_re,
    input  logic signed [WN_WID-1:0]  wn_im,
    input  logic signed [DAT_WID-1:0] top_re,
    input  logic signed [DAT_WID-1:0] top_im,
    input  logic signed [DAT_WID-1:0] bot_re,
    input  logic signed [DAT_WID-1:0] bot_im,
    output logic signed [DAT_WID-1:0] sum_re,
    output logic signed [DAT_WID-1:0] sum_im,
    output logic signed [DAT_WID-1:0] dif_re,
    output logic signed [DAT_WID-1:0] dif_im
);

    localparam logic signed [MUL_WID-1:0] RND = MUL_WID'(1 << (WN_FRAC - 1));

    logic signed [MUL_WID-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [MUL_WID-1:0] r_rr, r_ii, r_ri, r_ir;
    logic signed [MUL_WID-1:0] p_re_full, p_im_full;
    logic signed [PRD_WID-1:0] prd_re, prd_im;
    logic signed [SUM_WID-1:0] s_re, s_im, d_re, d_im;
    logic                      unused_bits;

    always_comb begin
        p_rr = MUL_WID'(wn_re) * MUL_WID'(bot_re);
        p_ii = MUL_WID'(wn_im) * MUL_WID'(bot_im);
        p_ri = MUL_WID'(wn_re) * MUL_WID'(bot_im);
        p_ir = MUL_WID'(wn_im) * MUL_WID'(bot_re);
        // Round-half-up each real product before combining.
        r_rr = (p_rr + RND) >>> WN_FRAC;
        r_ii = (p_ii + RND) >>> WN_FRAC;
        r_ri = (p_ri + RND) >>> WN_FRAC;
        r_ir = (p_ir + RND) >>> WN_FRAC;
        p_re_full = r_rr - r_ii;
        p_im_full = r_ri + r_ir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prd_re <= '0;
            prd_im <= '0;
        end else if (mul_en) begin
            prd_re <= p_re_full[PRD_WID-1:0];
            prd_im <= p_im_full[PRD_WID-1:0];
        end
    end

    always_comb begin
        s_re = SUM_WID'(top_re) + SUM_WID'(prd_re);
        s_im = SUM_WID'(top_im) + SUM_WID'(prd_im);
        d_re = SUM_WID'(top_re) - SUM_WID'(prd_re);
        d_im = SUM_WID'(top_im) - SUM_WID'(prd_im);
    end

    // Halving per stage: drop bit 0 (arithmetic >>1) and keep DAT_WID bits.
    assign sum_re = s_re[DAT_WID:1];
    assign sum_im = s_im[DAT_WID:1];
    assign dif_re = d_re[DAT_WID:1];
    assign dif_im = d_im[DAT_WID:1];

    assign unused_bits = ^{p_re_full[MUL_WID-1:PRD_WID], p_im_full[MUL_WID-1:PRD_WID],
                           s_re[SUM_WID-1], s_re[0], s_im[SUM_WID-1], s_im[0],
                           d_re[SUM_WID-1], d_re[0], d_im[SUM_WID-1], d_im[0]};

endmodule

// File: rtl/fft_bfly_engine.sv
// In-place radix-2 DIT FFT engine: FSM, stage counter, work registers and per-stage index muxing.
module fft_bfly_engine
    import fft_bfly_engine_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [FFT_LEN*DAT_WID-1:0]    dat_re_i,
    input  logic [FFT_LEN*DAT_WID-1:0]    dat_im_i,
    output logic [STG_WID-1:0]            stage_o,
    input  logic [BFLY_NUM*WN_WID-1:0]    fft_wn_re_i,
    input  logic [BFLY_NUM*WN_WID-1:0]    fft_wn_im_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [FFT_LEN*DAT_WID-1:0]    dat_re_o,
    output logic [FFT_LEN*DAT_WID-1:0]    dat_im_o,
    output state_t                        dbg_state
);

    // Handshake: start_i is a request honoured only in IDLE (no back-pressure elsewhere);
    // busy_o covers FETCH..ADD, done_o marks the one cycle where dat_*_o first holds the new frame.

    state_t                    state, state_nxt;
    logic [STG_WID-1:0]        stg_cnt;
    logic                      last_stg;
    logic signed [DAT_WID-1:0] x_re [FFT_LEN];
    logic signed [DAT_WID-1:0] x_im [FFT_LEN];
    logic signed [WN_WID-1:0]  wn_re_q [BFLY_NUM];
    logic signed [WN_WID-1:0]  wn_im_q [BFLY_NUM];

    logic [IDX_WID-1:0]        top_sel [BFLY_NUM];
    logic [IDX_WID-1:0]        bot_sel [BFLY_NUM];
    logic signed [DAT_WID-1:0] bt_re [BFLY_NUM];
    logic signed [DAT_WID-1:0] bt_im [BFLY_NUM];
    logic signed [DAT_WID-1:0] bb_re [BFLY_NUM];
    logic signed [DAT_WID-1:0] bb_im [BFLY_NUM];
    logic signed [DAT_WID-1:0] sum_re [BFLY_NUM];
    logic signed [DAT_WID-1:0] sum_im [BFLY_NUM];
    logic signed [DAT_WID-1:0] dif_re [BFLY_NUM];
    logic signed [DAT_WID-1:0] dif_im [BFLY_NUM];

    logic [BIDX_WID-1:0]       own_sel [FFT_LEN];
    logic                      own_bot [FFT_LEN];
    logic signed [DAT_WID-1:0] wb_re [FFT_LEN];
    logic signed [DAT_WID-1:0] wb_im [FFT_LEN];

    assign last_stg  = (stg_cnt == STG_WID'(STG_NUM - 1));
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        stage_o   = '0;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = ST_FETCH;
            ST_FETCH: begin
                state_nxt = ST_MUL;
                busy_o    = 1'b1;
                stage_o   = stg_cnt;
            end
            ST_MUL: begin
                state_nxt = ST_ADD;
                busy_o    = 1'b1;
                stage_o   = stg_cnt;
            end
            ST_ADD: begin
                state_nxt = last_stg ? ST_DONE : ST_FETCH;
                busy_o    = 1'b1;
                stage_o   = stg_cnt;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                done_o    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < BFLY_NUM; k++) begin
            top_sel[k] = top_idx(IDX_WID'(k), stg_cnt);
            bot_sel[k] = top_sel[k] | (IDX_WID'(1) << stg_cnt);
            bt_re[k]   = x_re[top_sel[k]];
            bt_im[k]   = x_im[top_sel[k]];
            bb_re[k]   = x_re[bot_sel[k]];
            bb_im[k]   = x_im[bot_sel[k]];
        end
    end

    for (genvar k = 0; k < BFLY_NUM; k++) begin : g_bfly
        fft_bfly_engine_bfly u_bfly (
            .clk    (clk),
            .rst    (rst),
            .mul_en (state == ST_MUL),
            .wn_re  (wn_re_q[k]),
            .wn_im  (wn_im_q[k]),
            .top_re (bt_re[k]),
            .top_im (bt_im[k]),
            .bot_re (bb_re[k]),
            .bot_im (bb_im[k]),
            .sum_re (sum_re[k]),
            .sum_im (sum_im[k]),
            .dif_re (dif_re[k]),
            .dif_im (dif_im[k])
        );
    end

    // Each sample is written back from the butterfly that read it, on the side it occupied.
    always_comb begin
        for (int n = 0; n < FFT_LEN; n++) begin
            own_sel[n] = owner_idx(IDX_WID'(n), stg_cnt);
            own_bot[n] = |(IDX_WID'(n) & (IDX_WID'(1) << stg_cnt));
            wb_re[n]   = own_bot[n] ? dif_re[own_sel[n]] : sum_re[own_sel[n]];
            wb_im[n]   = own_bot[n] ? dif_im[own_sel[n]] : sum_im[own_sel[n]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            stg_cnt  <= '0;
            dat_re_o <= '0;
            dat_im_o <= '0;
            for (int n = 0; n < FFT_LEN; n++) begin
                x_re[n] <= '0;
                x_im[n] <= '0;
            end
            for (int k = 0; k < BFLY_NUM; k++) begin
                wn_re_q[k] <= '0;
                wn_im_q[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start_i) begin
                    stg_cnt <= '0;
                    for (int n = 0; n < FFT_LEN; n++) begin
                        x_re[n] <= dat_re_i[n*DAT_WID +: DAT_WID];
                        x_im[n] <= dat_im_i[n*DAT_WID +: DAT_WID];
                    end
                end
                ST_FETCH: begin
                    for (int k = 0; k < BFLY_NUM; k++) begin
                        wn_re_q[k] <= fft_wn_re_i[k*WN_WID +: WN_WID];
                        wn_im_q[k] <= fft_wn_im_i[k*WN_WID +: WN_WID];
                    end
                end
                ST_ADD: begin
                    for (int n = 0; n < FFT_LEN; n++) begin
                        x_re[n] <= wb_re[n];
                        x_im[n] <= wb_im[n];
                    end
                    if (last_stg) begin
                        // Publish on the ADD->DONE edge so dat_*_o is valid alongside done_o.
                        stg_cnt <= '0;
                        for (int n = 0; n < FFT_LEN; n++) begin
                            dat_re_o[n*DAT_WID +: DAT_WID] <= wb_re[n];
                            dat_im_o[n*DAT_WID +: DAT_WID] <= wb_im[n];
                        end
                    end else begin
                        stg_cnt <= stg_cnt + STG_WID'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bfly_engine.sv
// Directed bench for fft_bfly_engine with a combinational 8-point twiddle generator model.
module tb_fft_bfly_engine;
    import fft_bfly_engine_pkg::*;

    logic                       clk;
    logic                       rst;
    logic                       start_i;
    logic [FFT_LEN*DAT_WID-1:0] dat_re_i;
    logic [FFT_LEN*DAT_WID-1:0] dat_im_i;
    logic [STG_WID-1:0]         stage_o;
    logic [BFLY_NUM*WN_WID-1:0] fft_wn_re_i;
    logic [BFLY_NUM*WN_WID-1:0] fft_wn_im_i;
    logic                       busy_o;
    logic                       done_o;
    logic [FFT_LEN*DAT_WID-1:0] dat_re_o;
    logic [FFT_LEN*DAT_WID-1:0] dat_im_o;
    state_t                     dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // W8^e = exp(-j*2*pi*e/8) scaled by 256
    int wr_tab [4] = '{256, 181, 0, -181};
    int wi_tab [4] = '{0, -181, -256, -181};

    int zero8    [8] = '{default: 0};
    int imp_in   [8] = '{100, 0, 0, 0, 0, 0, 0, 0};
    int imp_exp  [8] = '{default: 12};
    int dc_in    [8] = '{default: 64};
    int dc_exp   [8] = '{64, 0, 0, 0, 0, 0, 0, 0};
    int tone_in  [8] = '{128, -128, 0, 0, 91, -91, -91, 91};
    int tone_re  [8] = '{0, 64, 0, -1, 0, 0, 0, 64};
    int tone_im  [8] = '{0, 0, 0, 0, 0, 0, 0, -1};
    int neg_in   [8] = '{default: -32768};
    int neg_exp  [8] = '{-32768, 0, 0, 0, 0, 0, 0, 0};

    fft_bfly_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .dat_re_i    (dat_re_i),
        .dat_im_i    (dat_im_i),
        .stage_o     (stage_o),
        .fft_wn_re_i (fft_wn_re_i),
        .fft_wn_im_i (fft_wn_im_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dat_re_o    (dat_re_o),
        .dat_im_o    (dat_im_o),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // twiddle generator model
    always_comb begin
        int e;
        fft_wn_re_i = '0;
        fft_wn_im_i = '0;
        for (int k = 0; k < BFLY_NUM; k++) begin
            e = 0;
            case (stage_o)
                2'd0: e = 0;
                2'd1: e = (k & 1) * 2;
                2'd2: e = k & 3;
                default: e = -1;
            endcase
            if (e < 0) begin
                fft_wn_re_i[k*WN_WID +: WN_WID] = 10'h155;
                fft_wn_im_i[k*WN_WID +: WN_WID] = 10'h2aa;
            end else begin
                fft_wn_re_i[k*WN_WID +: WN_WID] = 10'(wr_tab[e]);
                fft_wn_im_i[k*WN_WID +: WN_WID] = 10'(wi_tab[e]);
            end
        end
    end

    // scoreboard
    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input int ere [8], input int eim [8]);
        for (int n = 0; n < FFT_LEN; n++) begin
            check($sformatf("%s_re%0d", tag, n), $signed(dat_re_o[n*DAT_WID +: DAT_WID]), ere[n]);
            check($sformatf("%s_im%0d", tag, n), $signed(dat_im_o[n*DAT_WID +: DAT_WID]), eim[n]);
        end
    endtask

    // drivers
    task automatic load_frame(input int re [8], input int im [8]);
        for (int n = 0; n < FFT_LEN; n++) begin
            dat_re_i[n*DAT_WID +: DAT_WID] = 16'(re[n]);
            dat_im_i[n*DAT_WID +: DAT_WID] = 16'(im[n]);
        end
    endtask

    // Returns at the negedge that observes cycle T+1 (T = edge that samples start_i).
    task automatic start_frame();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int from, output int at);
        at = from;
        while (done_o !== 1'b1 && at < from + 40) begin
            @(negedge clk);
            at++;
        end
        if (done_o !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic run_frame(input string tag, input int re [8], input int im [8],
                             input int ere [8], input int eim [8]);
        int at;
        load_frame(re, im);
        start_frame();
        wait_done(1, at);
        check({tag, "_latency"}, at, 10);
        check_result(tag, ere, eim);
        @(negedge clk);
        check({tag, "_done_pulse"}, done_o, 0);
    endtask

    initial begin
        int at;
        int done_cnt;
        rst      = 1'b1;
        start_i  = 1'b0;
        dat_re_i = '0;
        dat_im_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_stage", stage_o, 0);
        check("rst_state_idle", dbg_state == ST_IDLE, 1);
        check("rst_dat_re_zero", dat_re_o == '0, 1);
        check("rst_dat_im_zero", dat_im_o == '0, 1);
        rst = 1'b0;

        // impulse with cycle-accurate stage/busy/done trace
        load_frame(imp_in, zero8);
        start_frame();
        for (int n = 1; n <= 12; n++) begin
            check($sformatf("trace_stage_c%0d", n), stage_o,
                  (n >= 4 && n <= 6) ? 1 : ((n >= 7 && n <= 9) ? 2 : 0));
            check($sformatf("trace_busy_c%0d", n), busy_o, (n >= 1 && n <= 9) ? 1 : 0);
            check($sformatf("trace_done_c%0d", n), done_o, (n == 10) ? 1 : 0);
            if (n == 10) check_result("impulse", imp_exp, zero8);
            @(negedge clk);
        end

        run_frame("dc", dc_in, zero8, dc_exp, zero8);
        run_frame("tone", tone_in, zero8, tone_re, tone_im);
        run_frame("negfs", neg_in, zero8, neg_exp, zero8);

        // start_i while busy and in DONE is ignored; held into IDLE it is accepted
        load_frame(imp_in, zero8);
        start_frame();
        load_frame(dc_in, zero8);
        @(negedge clk);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("ign_busy_c4", busy_o, 1);
        check("ign_stage_c4", stage_o, 1);
        wait_done(4, at);
        check("ign_latency", at, 10);
        check_result("ign_busy", imp_exp, zero8);
        start_i = 1'b1;
        @(negedge clk);
        check("ign_done_c11", done_o, 0);
        check("ign_busy_c11", busy_o, 0);
        check_result("ign_done", imp_exp, zero8);
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_busy_c12", busy_o, 1);
        check("b2b_stage_c12", stage_o, 0);
        wait_done(1, at);
        check("b2b_latency", at, 10);
        check_result("b2b_dc", dc_exp, zero8);
        @(negedge clk);

        // reset mid-frame aborts without done_o
        load_frame(tone_in, zero8);
        start_frame();
        repeat (4) @(negedge clk);
        check("abort_busy_c5", busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_stage", stage_o, 0);
        check("abort_state_idle", dbg_state == ST_IDLE, 1);
        check("abort_dat_re_zero", dat_re_o == '0, 1);
        check("abort_dat_im_zero", dat_im_o == '0, 1);
        done_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) done_cnt++;
        end
        check("abort_no_activity", done_cnt, 0);
        run_frame("post_rst", imp_in, zero8, imp_exp, zero8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
